// File: rtl/rriot_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : rriot_bus_master
// Purpose  : Single-outstanding command/response bridge onto an RRIOT-style
//            peripheral bus. A command is accepted in IDLE. The bus is driven
//            for one DRIVE cycle. Reads then sit in WAIT until bus_oe or a
//            timeout. The response is held in RESP until it is consumed.
//            ROM writes are illegal: they skip the bus and return an error.
// Ports    : phi2 / rst_n        - clock, synchronous active-low reset
//            cmd_*               - command channel (valid/ready handshake)
//            rsp_*               - response channel (valid/ready handshake)
//            bus_*               - peripheral strobes, address and data
//            txn_count           - completed-response counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module rriot_bus_master #(
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             phi2,
  input  logic             rst_n,
  // command channel
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic             cmd_rom,
  input  logic [9:0]       cmd_addr,
  input  logic [7:0]       cmd_wdata,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_err,
  // peripheral bus
  output logic             bus_we_n,
  output logic [9:0]       bus_a,
  output logic [7:0]       bus_wdata,
  output logic             bus_rs_n,
  output logic             bus_cs1_n,
  output logic             bus_cs2_n,
  input  logic [7:0]       bus_rdata,
  input  logic             bus_oe,
  // statistics
  output logic [CNT_W-1:0] txn_count
);

  // Wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1.
  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCNT_W-1:0] C_WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q,     state_d;
  logic              we_q,        we_d;
  logic [WCNT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic [7:0]        rsp_data_q,  rsp_data_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]  txn_count_q, txn_count_d;
  logic              bus_we_n_q,  bus_we_n_d;
  logic [9:0]        bus_a_q,     bus_a_d;
  logic [7:0]        bus_wdata_q, bus_wdata_d;
  logic              bus_rs_n_q,  bus_rs_n_d;
  logic              bus_cs1_n_q, bus_cs1_n_d;
  logic              bus_cs2_n_q, bus_cs2_n_d;

  // Set whenever the next state releases the bus (entering RESP or IDLE).
  logic              bus_release;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    txn_count_d = txn_count_q;
    bus_we_n_d  = bus_we_n_q;
    bus_a_d     = bus_a_q;
    bus_wdata_d = bus_wdata_q;
    bus_rs_n_d  = bus_rs_n_q;
    bus_cs1_n_d = bus_cs1_n_q;
    bus_cs2_n_d = bus_cs2_n_q;
    bus_release = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          we_d = cmd_we;
          if (cmd_we && cmd_rom) begin
            // Writing ROM is illegal: never touch the bus.
            state_d     = S_RESP;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 8'h00;
            bus_release = 1'b1;
          end else begin
            // The bus registers double as the latched address, data and
            // space of the command for the rest of the transaction.
            state_d     = S_DRIVE;
            bus_cs1_n_d = 1'b0;
            bus_cs2_n_d = 1'b0;
            bus_a_d     = cmd_addr;
            bus_rs_n_d  = ~cmd_rom;
            bus_we_n_d  = ~cmd_we;
            bus_wdata_d = cmd_we ? cmd_wdata : 8'h00;
          end
        end
      end

      S_DRIVE: begin
        if (we_q) begin
          // The peripheral took the write on the edge that ends DRIVE.
          state_d     = S_RESP;
          rsp_err_d   = 1'b0;
          rsp_data_d  = 8'h00;
          bus_release = 1'b1;
        end else begin
          // Bus values stay as driven for the whole wait.
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end

      S_WAIT: begin
        // bus_oe is checked first so data arriving in the last allowed
        // cycle still counts as success.
        if (bus_oe) begin
          state_d     = S_RESP;
          rsp_err_d   = 1'b0;
          rsp_data_d  = bus_rdata;
          bus_release = 1'b1;
        end else if (wait_cnt_q == C_WAIT_LAST) begin
          state_d     = S_RESP;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 8'hFF;
          bus_release = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          txn_count_d = txn_count_q + CNT_W'(1);
        end
      end

      default: begin
        state_d     = S_IDLE;
        bus_release = 1'b1;
      end
    endcase

    if (bus_release) begin
      bus_cs1_n_d = 1'b1;
      bus_cs2_n_d = 1'b1;
      bus_rs_n_d  = 1'b1;
      bus_we_n_d  = 1'b1;
      bus_a_d     = 10'h000;
      bus_wdata_d = 8'h00;
    end
  end

  always_ff @(posedge phi2) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      wait_cnt_q  <= '0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      txn_count_q <= '0;
      bus_we_n_q  <= 1'b1;
      bus_a_q     <= 10'h000;
      bus_wdata_q <= 8'h00;
      bus_rs_n_q  <= 1'b1;
      bus_cs1_n_q <= 1'b1;
      bus_cs2_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      txn_count_q <= txn_count_d;
      bus_we_n_q  <= bus_we_n_d;
      bus_a_q     <= bus_a_d;
      bus_wdata_q <= bus_wdata_d;
      bus_rs_n_q  <= bus_rs_n_d;
      bus_cs1_n_q <= bus_cs1_n_d;
      bus_cs2_n_q <= bus_cs2_n_d;
    end
  end

  // Handshake flags are pure decodes of the registered state.
  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign txn_count = txn_count_q;
  assign bus_we_n  = bus_we_n_q;
  assign bus_a     = bus_a_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_rs_n  = bus_rs_n_q;
  assign bus_cs1_n = bus_cs1_n_q;
  assign bus_cs2_n = bus_cs2_n_q;

endmodule
`default_nettype wire
